// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : arb_pkg
//  Description : Shared types and constants for the round-robin burst arbiter
//                (opcode, FSM state, default-width command record).
//  Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

    localparam int ARB_NREQ_MAX  = 8;
    localparam int ARB_OP_W      = 2;
    localparam int ARB_LEN_W_DEF = 4;

    typedef enum logic [1:0] {
        OP_RD  = 2'd0,
        OP_WR  = 2'd1,
        OP_RMW = 2'd2,
        OP_NOP = 2'd3
    } op_t;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_XFER = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Command record at the default burst-length width; len sits in the LSBs.
    typedef struct packed {
        op_t                      op;
        logic [ARB_LEN_W_DEF-1:0] len;
    } cmd_t;

    // Increment with wrap at n-1 -> 0.
    function automatic int wrap_inc(input int v, input int n);
        return (v + 1 >= n) ? 0 : v + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational round-robin winner select: first set request
//                at or after the pointer, wrapping from NREQ-1 back to 0.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ  = 4,
    parameter int IDX_W = $clog2(NREQ)
) (
    input  logic [NREQ-1:0]  req,
    input  logic [IDX_W-1:0] rr_ptr,
    output logic [NREQ-1:0]  win_oh,
    output logic [IDX_W-1:0] win_idx,
    output logic             win_vld
);

    // Scan NREQ positions starting at the pointer; the first hit wins.
    always_comb begin
        win_oh  = '0;
        win_idx = '0;
        win_vld = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            int               pos;
            logic [IDX_W-1:0] sel;
            pos = int'(rr_ptr) + k;
            if (pos >= NREQ) begin
                pos = pos - NREQ;
            end
            sel = IDX_W'(pos);
            if (!win_vld && req[sel]) begin
                win_vld     = 1'b1;
                win_idx     = sel;
                win_oh[sel] = 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : rr_burst_arbiter
//  Description : Round-robin burst arbiter. Grants one requester at a time,
//                sequences len+1 beats under valid/ready, inserts a one-cycle
//                gap, then rotates priority past the last owner.
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_burst_arbiter
    import arb_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int LEN_W = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [NREQ-1:0]                req,
    input  logic [NREQ*(ARB_OP_W+LEN_W)-1:0] cmd,
    input  logic                           res_ready,
    output logic [NREQ-1:0]                gnt,
    output logic [$clog2(NREQ)-1:0]        gnt_id,
    output logic                           beat_valid,
    output logic                           beat_last,
    output op_t                            beat_op,
    output logic                           busy
);

    localparam int CMD_W = ARB_OP_W + LEN_W;
    localparam int IDX_W = $clog2(NREQ);

    state_t             state_q,  state_d;
    logic [NREQ-1:0]    gnt_q,    gnt_d;
    logic [IDX_W-1:0]   gnt_id_q, gnt_id_d;
    op_t                op_q,     op_d;
    logic [LEN_W-1:0]   cnt_q,    cnt_d;
    logic [IDX_W-1:0]   rr_ptr_q, rr_ptr_d;

    logic [NREQ-1:0]    win_oh;
    logic [IDX_W-1:0]   win_idx;
    logic               win_vld;
    logic [CMD_W-1:0]   win_cmd;
    op_t                win_op;
    logic [LEN_W-1:0]   win_len;

    rr_pick #(
        .NREQ  (NREQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .req     (req),
        .rr_ptr  (rr_ptr_q),
        .win_oh  (win_oh),
        .win_idx (win_idx),
        .win_vld (win_vld)
    );

    // Extract the winner's command so it can be captured at the grant.
    always_comb begin
        win_cmd = cmd[int'(win_idx)*CMD_W +: CMD_W];
        win_op  = op_t'(win_cmd[CMD_W-1 -: ARB_OP_W]);
        win_len = win_cmd[LEN_W-1:0];
    end

    // Next-state logic: grant in IDLE, count beats in XFER, one-cycle GAP.
    always_comb begin
        state_d  = state_q;
        gnt_d    = gnt_q;
        gnt_id_d = gnt_id_q;
        op_d     = op_q;
        cnt_d    = cnt_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (win_vld) begin
                    state_d  = S_XFER;
                    gnt_d    = win_oh;
                    gnt_id_d = win_idx;
                    op_d     = win_op;
                    cnt_d    = win_len;
                end
            end
            S_XFER: begin
                if (res_ready) begin
                    if (cnt_q == '0) begin
                        state_d  = S_GAP;
                        gnt_d    = '0;
                        op_d     = OP_RD;
                        rr_ptr_d = IDX_W'(wrap_inc(int'(gnt_id_q), NREQ));
                    end else begin
                        cnt_d = cnt_q - 1'b1;
                    end
                end
            end
            S_GAP: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            gnt_q    <= '0;
            gnt_id_q <= '0;
            op_q     <= OP_RD;
            cnt_q    <= '0;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            gnt_q    <= gnt_d;
            gnt_id_q <= gnt_id_d;
            op_q     <= op_d;
            cnt_q    <= cnt_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    // Outputs are decoded from registers only.
    assign gnt        = gnt_q;
    assign gnt_id     = gnt_id_q;
    assign beat_op    = op_q;
    assign beat_valid = (state_q == S_XFER);
    assign beat_last  = (state_q == S_XFER) && (cnt_q == '0);
    assign busy       = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rr_burst_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_rr_burst_arbiter
//  Description : Self-checking bench for rr_burst_arbiter: vector table,
//                directed corner sequences, randomized run against a model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_rr_burst_arbiter;
    import arb_pkg::*;

    localparam int NREQ  = 4;
    localparam int LEN_W = 4;
    localparam int CW    = 2 + LEN_W;

    logic               clk = 1'b0;
    logic               rst_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*CW-1:0] cmd;
    logic               res_ready;
    logic [NREQ-1:0]    gnt;
    logic [1:0]         gnt_id;
    logic               beat_valid;
    logic               beat_last;
    op_t                beat_op;
    logic               busy;

    int checks = 0;
    int errors = 0;

    rr_burst_arbiter #(.NREQ(NREQ), .LEN_W(LEN_W)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .cmd        (cmd),
        .res_ready  (res_ready),
        .gnt        (gnt),
        .gnt_id     (gnt_id),
        .beat_valid (beat_valid),
        .beat_last  (beat_last),
        .beat_op    (beat_op),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic set_cmd(input int who, input logic [1:0] op, input logic [3:0] len);
        cmd[who*CW +: CW] = {op, len};
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0; req = '0; cmd = '0; res_ready = 1'b1;
        step(); step();
        rst_n = 1'b1;
    endtask

    // ---------------- vector table ----------------
    typedef struct {
        logic       rst_n;
        logic [3:0] req;
        int         who;
        logic [1:0] op;
        logic [3:0] len;
        logic       rdy;
        int         e_gnt;
        int         e_id;    // -1: don't care
        int         e_valid;
        int         e_last;
        int         e_op;    // -1: don't care
        int         e_busy;
        int         e_ptr;   // -1: don't care
    } vec_t;

    vec_t vt[$];

    function automatic vec_t mk(input logic [3:0] r, input int who, input logic [1:0] op,
                                input logic [3:0] len, input logic rdy, input int eg,
                                input int eid, input int ev, input int el, input int eop,
                                input int eb, input int ep);
        vec_t v;
        v.rst_n = 1'b1; v.req = r; v.who = who; v.op = op; v.len = len; v.rdy = rdy;
        v.e_gnt = eg; v.e_id = eid; v.e_valid = ev; v.e_last = el; v.e_op = eop;
        v.e_busy = eb; v.e_ptr = ep;
        return v;
    endfunction

    // ---------------- reference model ----------------
    int          m_owner, m_left, m_ptr, m_op;
    bit          m_gap;

    function automatic int pick(input logic [3:0] r, input int p);
        for (int k = 0; k < NREQ; k++) begin
            int i;
            i = (p + k) % NREQ;
            if (r[i]) return i;
        end
        return -1;
    endfunction

    task automatic model_edge(input logic rn, input logic [3:0] r,
                              input logic [NREQ*CW-1:0] c, input logic rdy);
        if (!rn) begin
            m_owner = -1; m_gap = 0; m_ptr = 0;
        end else if (m_owner >= 0) begin
            if (rdy) begin
                m_left--;
                if (m_left == 0) begin
                    m_ptr = (m_owner + 1) % NREQ;
                    m_owner = -1;
                    m_gap = 1;
                end
            end
        end else if (m_gap) begin
            m_gap = 0;
        end else begin
            int w;
            w = pick(r, m_ptr);
            if (w >= 0) begin
                m_owner = w;
                m_left  = int'(c[w*CW +: LEN_W]) + 1;
                m_op    = int'(c[w*CW + LEN_W +: 2]);
            end
        end
    endtask

    initial begin
        int rr_ids[$];
        int rr_t[$];
        int beats, badop, guard;

        rst_n = 1'b0; req = '0; cmd = '0; res_ready = 1'b0;

        // Reset then idle
        step(); step();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_outputs", int'({gnt, gnt_id, beat_valid, beat_last, beat_op, busy}), 0);
        end
        chk("reset_ptr", int'(dut.rr_ptr_q), 0);

        // Table: single burst then stalled burst
        vt.push_back(mk(4'b0100, 2, OP_WR, 4'd2, 1, 4'b0100, 2, 1, 0, OP_WR, 1, -1));
        vt.push_back(mk(4'b0100, 2, OP_WR, 4'd2, 1, 4'b0100, 2, 1, 0, OP_WR, 1, -1));
        vt.push_back(mk(4'b0100, 2, OP_WR, 4'd2, 1, 4'b0100, 2, 1, 1, OP_WR, 1, -1));
        vt.push_back(mk(4'b0100, 2, OP_WR, 4'd2, 1, 0,      -1, 0, 0, -1,    1,  3));
        vt.push_back(mk(4'b0000, 2, OP_WR, 4'd2, 1, 0,      -1, 0, 0, -1,    0,  3));
        vt.push_back(mk(4'b0001, 0, OP_RD, 4'd3, 1, 4'b0001, 0, 1, 0, OP_RD, 1, -1));
        vt.push_back(mk(4'b0001, 0, OP_RD, 4'd3, 1, 4'b0001, 0, 1, 0, OP_RD, 1, -1));
        vt.push_back(mk(4'b0001, 0, OP_RD, 4'd3, 0, 4'b0001, 0, 1, 0, OP_RD, 1, -1));
        vt.push_back(mk(4'b0001, 0, OP_RD, 4'd3, 0, 4'b0001, 0, 1, 0, OP_RD, 1, -1));
        vt.push_back(mk(4'b0001, 0, OP_RD, 4'd3, 1, 4'b0001, 0, 1, 0, OP_RD, 1, -1));
        vt.push_back(mk(4'b0001, 0, OP_RD, 4'd3, 1, 4'b0001, 0, 1, 1, OP_RD, 1, -1));
        vt.push_back(mk(4'b0001, 0, OP_RD, 4'd3, 0, 4'b0001, 0, 1, 1, OP_RD, 1, -1));
        vt.push_back(mk(4'b0001, 0, OP_RD, 4'd3, 1, 0,      -1, 0, 0, -1,    1, -1));
        vt.push_back(mk(4'b0000, 0, OP_RD, 4'd3, 1, 0,      -1, 0, 0, -1,    0,  1));
        foreach (vt[i]) begin
            rst_n = vt[i].rst_n; req = vt[i].req; res_ready = vt[i].rdy;
            cmd = '0;
            set_cmd(vt[i].who, vt[i].op, vt[i].len);
            step();
            chk($sformatf("tbl%0d_gnt", i), int'(gnt), vt[i].e_gnt);
            chk($sformatf("tbl%0d_valid", i), int'(beat_valid), vt[i].e_valid);
            chk($sformatf("tbl%0d_last", i), int'(beat_last), vt[i].e_last);
            chk($sformatf("tbl%0d_busy", i), int'(busy), vt[i].e_busy);
            if (vt[i].e_id >= 0) chk($sformatf("tbl%0d_id", i), int'(gnt_id), vt[i].e_id);
            if (vt[i].e_op >= 0) chk($sformatf("tbl%0d_op", i), int'(beat_op), vt[i].e_op);
            if (vt[i].e_ptr >= 0) chk($sformatf("tbl%0d_ptr", i), int'(dut.rr_ptr_q), vt[i].e_ptr);
        end

        // Round-robin with all requesters active, single-beat bursts
        do_reset();
        req = 4'b1111; res_ready = 1'b1;
        for (int w = 0; w < NREQ; w++) set_cmd(w, OP_RD, 4'd0);
        for (int c = 1; c <= 16; c++) begin
            step();
            if (gnt != '0) begin
                rr_ids.push_back(int'(gnt_id));
                rr_t.push_back(c);
            end
        end
        chk("rr_grant_count", (rr_ids.size() >= 5) ? 1 : 0, 1);
        if (rr_ids.size() >= 5) begin
            for (int k = 0; k < 5; k++) begin
                chk($sformatf("rr_order%0d", k), rr_ids[k], k % NREQ);
                if (k > 0) chk($sformatf("rr_spacing%0d", k), rr_t[k] - rr_t[k-1], 3);
            end
        end

        // Mid-burst request drop and command change are ignored
        do_reset();
        step();
        req = 4'b0010; res_ready = 1'b1; set_cmd(1, OP_RMW, 4'd5);
        step();
        chk("mid_gnt", int'(gnt), 4'b0010);
        req = 4'b0000; set_cmd(1, OP_RD, 4'd0);
        beats = 0; badop = 0; guard = 0;
        while (beat_valid && guard < 40) begin
            beats++;
            if (beat_op != OP_RMW) badop++;
            step();
            guard++;
        end
        chk("mid_beats", beats, 6);
        chk("mid_op_kept", badop, 0);

        // Reset in the middle of an 8-beat burst
        do_reset();
        req = 4'b0100; res_ready = 1'b1; set_cmd(2, OP_WR, 4'd7);
        step();
        chk("rstmid_gnt", int'(gnt), 4'b0100);
        step();
        chk("rstmid_beat2", int'(beat_valid), 1);
        rst_n = 1'b0;
        step();
        chk("rstmid_outputs", int'({gnt, gnt_id, beat_valid, beat_last, beat_op, busy}), 0);
        chk("rstmid_ptr", int'(dut.rr_ptr_q), 0);
        rst_n = 1'b1; req = 4'b0010; set_cmd(1, OP_NOP, 4'd0);
        step();
        chk("rstmid_regrant", int'(gnt), 4'b0010);
        chk("rstmid_regrant_id", int'(gnt_id), 1);
        chk("rstmid_regrant_op", int'(beat_op), int'(OP_NOP));

        // Randomized run against the reference model
        do_reset();
        m_owner = -1; m_gap = 0; m_ptr = 0; m_left = 0; m_op = 0;
        for (int n = 0; n < 3000; n++) begin
            logic [NREQ-1:0] egnt;
            rst_n     = ($urandom_range(0, 199) != 0);
            req       = ($urandom_range(0, 3) == 0) ? 4'b0000 : 4'($urandom);
            cmd       = (NREQ*CW)'({$urandom, $urandom});
            res_ready = ($urandom_range(0, 3) != 0);
            step();
            model_edge(rst_n, req, cmd, res_ready);
            egnt = (m_owner >= 0) ? NREQ'(1 << m_owner) : '0;
            chk("rnd_gnt", int'(gnt), int'(egnt));
            chk("rnd_valid", int'(beat_valid), (m_owner >= 0) ? 1 : 0);
            chk("rnd_last", int'(beat_last), (m_owner >= 0 && m_left == 1) ? 1 : 0);
            chk("rnd_busy", int'(busy), (m_owner >= 0 || m_gap) ? 1 : 0);
            if (m_owner >= 0) begin
                chk("rnd_id", int'(gnt_id), m_owner);
                chk("rnd_op", int'(beat_op), m_op);
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_burst_arbiter.md
# rr_burst_arbiter

Round-robin burst arbiter sharing a single nibble-wide datapath resource among `NREQ` requesters. Each requester presents a packed command (opcode + burst length); the arbiter grants one requester at a time, sequences `len+1` beats into the resource under a valid/ready handshake, and then rotates priority. It sits between the requester front-ends and the shared resource, and is the only block that drives the resource's beat interface.

## Interface
- `NREQ`, 4, number of requesters (2..8)
- `LEN_W`, 4, burst-length field width; a burst is `len+1` beats, 1..2**LEN_W

- `clk`  in  1  single clock, rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `req`  in  NREQ  per-requester request level
- `cmd`  in  NREQ x cmd_t  per-requester command: `{op_t op; logic [LEN_W-1:0] len}`, packed, requester 0 in LSBs
- `res_ready`  in  1  resource accepts the current beat
- `gnt`  out  NREQ  one-hot grant, held for the whole burst
- `gnt_id`  out  $clog2(NREQ)  index of granted requester
- `beat_valid`  out  1  beat presented to resource
- `beat_last`  out  1  current beat is the final beat of the burst
- `beat_op`  out  op_t  opcode of the active burst
- `busy`  out  1  state != S_IDLE

## Operation
- States (`state_t`, enum logic [1:0]): `S_IDLE=0`, `S_XFER=1`, `S_GAP=2`.
- S_IDLE: if any `req` bit is set, pick a winner via round-robin starting at pointer `rr_ptr`. Register `gnt`, `gnt_id`, `beat_op`, and a beat counter loaded with `cmd[winner].len`. Go to S_XFER. With no requests, stay in S_IDLE.
- S_XFER: `beat_valid=1`. A beat completes on `beat_valid && res_ready`, and each completed beat decrements the counter. `beat_last=1` while counter == 0. Completion with counter == 0 clears `gnt`, sets `rr_ptr = gnt_id+1` (mod NREQ), and moves to S_GAP.
- S_GAP: exactly one cycle; all beat outputs and `gnt` are 0. Then go to S_IDLE.
- `cmd` is captured only at the grant. Changes to `cmd` or deassertion of `req` during S_XFER are ignored; the burst always runs to completion.
- Round-robin: the first set `req` bit at or after `rr_ptr`, wrapping at NREQ-1 -> 0.
- Counter width is LEN_W; `len = 2**LEN_W-1` gives the maximum burst, with no overflow.
- Opcode enum `op_t` (enum logic [1:0]): `OP_RD=0`, `OP_WR=1`, `OP_RMW=2`, `OP_NOP=3`. `OP_NOP` bursts are sequenced identically; the arbiter does not interpret the opcode.

## Timing
- Reset values (next edge with `rst_n=0`): `state=S_IDLE`, `gnt=0`, `gnt_id=0`, `beat_valid=0`, `beat_last=0`, `beat_op=OP_RD`, `busy=0`, `rr_ptr=0`, counter 0.
- Reset asserted mid-burst aborts the burst at that edge. No further beats are issued.
- Latency: `req` high in cycle N (S_IDLE) gives `gnt` and `beat_valid` in cycle N+1.
- Minimum burst occupancy is `len+1` cycles of S_XFER plus 1 cycle of S_GAP. Back-to-back grants are therefore separated by 2 idle cycles (S_GAP, S_IDLE).
- `res_ready=0` stalls the burst. `beat_valid`, `beat_last` and the counter hold. There is no timeout.
- All outputs are registered; none depends combinationally on `req`, `cmd` or `res_ready`.

## Structure
- Package `arb_pkg`: `op_t`, `state_t`, parameterised `cmd_t` (packed struct, `len` in LSBs, `op` above it), and the constant `ARB_NREQ_MAX = 8`.
- Sub-module `rr_pick`: purely combinational; inputs `req` and `rr_ptr`; outputs a one-hot winner and its index. It is instantiated once.
- Top-level FSM, counter and output registers live in `rr_burst_arbiter`.

## Test plan
- Reset, then idle: `rst_n` low for 2 cycles, no `req` -> all outputs 0, `busy=0` for 10 cycles.
- Single burst: `req=4'b0100`, `cmd[2]={OP_WR,4'd2}`, `res_ready=1` -> `gnt=4'b0100` and `gnt_id=2` from the next cycle; 3 beats with `beat_last` on the 3rd; one S_GAP cycle; `rr_ptr=3`.
- Round-robin: `req=4'b1111` held, all `len=0` -> grant order 0,1,2,3,0, each grant separated by 2 non-granted cycles.
- Stall: `len=3`, `res_ready` toggles 1,0,0,1,1,0,1 -> exactly 4 accepted beats; `beat_valid` never drops during stalls; `beat_last` only on the 4th.
- Mid-burst changes: after grant to requester 1 (`len=5`), drop `req[1]` and change `cmd[1].len` to 0 -> still 6 beats with the original opcode.
- Reset mid-burst: `rst_n=0` on beat 2 of 8 -> next cycle all outputs 0, `rr_ptr=0`; a new `req=4'b0010` after reset is granted to requester 1 normally.
